// File: rtl/song_pkg.sv
// Shared widths, markers and recorder state encoding for the song RAM
// reader/writer pair.
package song_pkg;

    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 6;
    localparam int ENTRY_W = 12;

    localparam logic [NOTE_W-1:0]  NOTE_REST  = '0;
    localparam logic [ENTRY_W-1:0] END_MARKER = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FLUSH,
        ST_TERM
    } rec_state_t;

    function automatic logic [ENTRY_W-1:0] make_entry(
        input logic [NOTE_W-1:0] note,
        input logic [DUR_W-1:0]  dur
    );
        return {note, dur};
    endfunction

endpackage

// File: rtl/duration_counter.sv
// Beat-driven saturating duration counter; exposes next value so the
// recorder can decide on this cycle's beat without waiting a cycle.
import song_pkg::*;

module duration_counter #(
    parameter int MAX_DUR = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             beat,
    output logic [DUR_W-1:0] count,
    output logic [DUR_W-1:0] next,
    output logic             at_max
);

    localparam logic [DUR_W-1:0] MAX_V = DUR_W'(MAX_DUR);

    always_comb begin
        next = count;
        if (beat && count != MAX_V)
            next = count + DUR_W'(1);
    end

    assign at_max = (next == MAX_V);

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else
            count <= next;
    end

endmodule

// File: rtl/song_recorder.sv
// Records live notes with their beat durations into the song RAM,
// closing each recording with an end-of-song marker.
import song_pkg::*;

module song_recorder #(
    parameter int IDX_W   = 5,
    parameter int MAX_DUR = 63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               record_button,
    input  logic [1:0]         song,
    input  logic               beat,
    input  logic [NOTE_W-1:0]  key_note,
    output logic               wr_en,
    output logic [IDX_W+1:0]   wr_addr,
    output logic [ENTRY_W-1:0] wr_data,
    output logic               recording,
    output logic               full
);

    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'((2 ** IDX_W) - 2);
    localparam logic [DUR_W-1:0] MAX_V     = DUR_W'(MAX_DUR);

    rec_state_t         state, state_n;
    logic [1:0]         song_l, song_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [NOTE_W-1:0]  cur_note, note_n;
    logic               full_n;
    logic               do_wr;
    logic [ENTRY_W-1:0] wdata;
    logic               dur_clear;
    logic [DUR_W-1:0]   dur, dur_next;
    logic               dur_at_max;

    duration_counter #(
        .MAX_DUR(MAX_DUR)
    ) u_dur (
        .clk   (clk),
        .reset (reset),
        .clear (dur_clear),
        .beat  (beat),
        .count (dur),
        .next  (dur_next),
        .at_max(dur_at_max)
    );

    always_comb begin
        state_n   = state;
        song_n    = song_l;
        idx_n     = idx;
        note_n    = cur_note;
        full_n    = full;
        do_wr     = 1'b0;
        wdata     = END_MARKER;
        dur_clear = (state != ST_CAPTURE);

        unique case (state)
            ST_IDLE: begin
                if (record_button) begin
                    song_n  = song;
                    idx_n   = '0;
                    note_n  = key_note;
                    full_n  = 1'b0;
                    state_n = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (record_button) begin
                    state_n = (dur_next != '0) ? ST_FLUSH : ST_TERM;
                end else if (key_note != cur_note) begin
                    // A change before the first beat just retargets the note
                    note_n = key_note;
                    if (dur_next != '0) begin
                        do_wr     = 1'b1;
                        wdata     = make_entry(cur_note, dur_next);
                        dur_clear = 1'b1;
                    end
                end else if (beat && dur_at_max) begin
                    do_wr     = 1'b1;
                    wdata     = make_entry(cur_note, MAX_V);
                    dur_clear = 1'b1;
                end
            end
            ST_FLUSH: begin
                do_wr   = 1'b1;
                wdata   = make_entry(cur_note, dur);
                state_n = ST_TERM;
            end
            ST_TERM: begin
                do_wr   = 1'b1;
                wdata   = END_MARKER;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // Data writes advance the index; the last slot is kept for the marker
        if (do_wr && state != ST_TERM) begin
            idx_n = idx + IDX_W'(1);
            if (idx == LAST_DATA) begin
                full_n  = 1'b1;
                state_n = ST_TERM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            song_l   <= '0;
            idx      <= '0;
            cur_note <= '0;
            full     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_n;
            song_l   <= song_n;
            idx      <= idx_n;
            cur_note <= note_n;
            full     <= full_n;
            wr_en    <= do_wr;
            wr_addr  <= do_wr ? {song_l, idx} : '0;
            wr_data  <= do_wr ? wdata : '0;
        end
    end

    assign recording = (state != ST_IDLE);

endmodule

// File: tb/tb_song_recorder.sv
// Scoreboard bench for song_recorder: a note/beat-level model queues
// expected RAM writes, a negedge monitor pops and compares them.
module tb_song_recorder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        record_button = 1'b0;
    logic [1:0]  song = 2'd0;
    logic        beat = 1'b0;
    logic [5:0]  key_note = 6'd0;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [11:0] wr_data;
    logic        recording;
    logic        full;

    song_recorder #(
        .IDX_W  (5),
        .MAX_DUR(63)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .record_button(record_button),
        .song         (song),
        .beat         (beat),
        .key_note     (key_note),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .recording    (recording),
        .full         (full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int seen = 0;
    bit mon_on = 0;

    logic [18:0] exp_q[$];

    // Model: 0 idle, 1 capturing, 2 stop with pending entry, 3 marker due
    int m_act = 0;
    int m_song = 0;
    int m_idx = 0;
    int m_note = 0;
    int m_dur = 0;
    bit m_full = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void m_entry(input int n, input int d);
        exp_q.push_back({7'(m_song * 32 + m_idx), 6'(n), 6'(d)});
        if (m_idx == 30) begin
            m_full = 1;
            m_act = 3;
        end
        m_idx++;
    endfunction

    function automatic void model_step(input int k, input bit bt,
                                       input bit bn);
        int d;
        case (m_act)
            0: if (bn) begin
                m_song = int'(song);
                m_idx = 0;
                m_note = k;
                m_dur = 0;
                m_full = 0;
                m_act = 1;
            end
            1: begin
                d = m_dur + (bt ? 1 : 0);
                if (bn) begin
                    m_dur = d;
                    m_act = (d > 0) ? 2 : 3;
                end else if (k != m_note) begin
                    if (d > 0) m_entry(m_note, d);
                    m_note = k;
                    m_dur = 0;
                end else if (d == 63) begin
                    m_entry(m_note, 63);
                    m_dur = 0;
                end else begin
                    m_dur = d;
                end
            end
            2: begin
                m_act = 3;
                m_entry(m_note, m_dur);
            end
            default: begin
                exp_q.push_back({7'(m_song * 32 + m_idx), 12'h000});
                m_act = 0;
            end
        endcase
    endfunction

    task automatic cyc(input int k, input bit bt, input bit bn);
        key_note = 6'(k);
        beat = bt;
        record_button = bn;
        @(posedge clk);
        model_step(k, bt, bn);
        #1;
        beat = 1'b0;
        record_button = 1'b0;
    endtask

    task automatic beats(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(k, 0, 0);
            cyc(k, 0, 0);
            cyc(k, 1, 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        m_act = 0;
        m_full = 0;
        m_idx = 0;
        m_dur = 0;
        #1;
        @(negedge clk);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_recording", int'(recording), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_queue", exp_q.size(), 0);
        reset = 1'b0;
    endtask

    task automatic settle_and_count(input string name, input int base,
                                    input int req);
        cyc(int'(key_note), 0, 0);
        cyc(int'(key_note), 0, 0);
        cyc(int'(key_note), 0, 0);
        @(negedge clk);
        chk(name, seen - base, req);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (wr_en) begin
                seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0d data=%0h",
                             wr_addr, wr_data);
                end else begin
                    logic [18:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(wr_addr), int'(e[18:12]));
                    chk("wr_data", int'(wr_data), int'(e[11:0]));
                end
            end
            chk("recording", int'(recording), (m_act != 0) ? 1 : 0);
            chk("full", int'(full), int'(m_full));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        int guard;
        @(posedge clk);
        do_reset();
        mon_on = 1;

        // Note 20 for 3 beats, rest for 2 beats, stop
        song = 2'd2;
        base = seen;
        cyc(20, 0, 1);
        beats(20, 3);
        beats(0, 2);
        cyc(0, 0, 1);
        settle_and_count("t1_writes", base, 3);

        // Sub-beat glitches 5 -> 7 -> 9 are dropped
        song = 2'd1;
        base = seen;
        cyc(5, 0, 1);
        cyc(7, 0, 0);
        cyc(9, 0, 0);
        beats(9, 1);
        cyc(9, 0, 1);
        settle_and_count("t2_writes", base, 2);

        // Long hold splits at 63
        song = 2'd3;
        base = seen;
        cyc(12, 0, 1);
        beats(12, 130);
        cyc(12, 0, 1);
        settle_and_count("t3_writes", base, 4);

        // Key change coinciding with a beat
        song = 2'd0;
        base = seen;
        cyc(3, 0, 1);
        beats(3, 1);
        cyc(14, 1, 0);
        beats(14, 2);
        cyc(14, 0, 1);
        settle_and_count("t4_writes", base, 3);

        // Fill all 31 data slots
        song = 2'd1;
        base = seen;
        cyc(1, 0, 1);
        for (int n = 1; n <= 32; n++) beats(n, 1);
        settle_and_count("t5_writes", base, 32);
        chk("t5_full", int'(full), 1);
        base = seen;
        beats(40, 1);
        beats(41, 1);
        settle_and_count("t5_no_writes", base, 0);

        // Reset mid-recording, then restart
        song = 2'd2;
        cyc(7, 0, 1);
        beats(7, 2);
        base = seen;
        do_reset();
        cyc(7, 0, 0);
        cyc(7, 0, 0);
        @(negedge clk);
        chk("t6_no_writes", seen - base, 0);
        cyc(8, 0, 1);
        beats(8, 1);
        cyc(8, 0, 1);
        settle_and_count("t6_restart", base, 2);

        // Randomized recordings
        for (int r = 0; r < 25; r++) begin
            song = 2'($urandom_range(0, 3));
            k = $urandom_range(0, 4);
            cyc(k, 0, 1);
            guard = 0;
            while (m_act != 0 && guard < 400) begin
                if ($urandom_range(0, 3) == 0) k = $urandom_range(0, 4);
                cyc(k, ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 80) == 0));
                guard++;
            end
            guard = 0;
            while (m_act != 0 && guard < 5) begin
                cyc(k, 0, 1);
                guard++;
            end
            chk("rand_stopped", m_act, 0);
            cyc(k, 0, 0);
            cyc(k, 0, 0);
        end

        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/song_recorder.md
# song_recorder

Captures notes played live on a note source (keypad or note selector), measures how many beats each note is held, and writes `{note, duration}` entries into the song RAM. It is the writer counterpart of `song_reader`, sharing its beat timebase and its per-song address space. A recorded song can then be selected and played back through the normal `mcu`/`song_reader` path.

## Interface
**Parameters**
- `IDX_W`, 5: entry index width; 2^IDX_W entries per song.
- `MAX_DUR`, 63: saturation value of the 6-bit duration field.

**Ports**
- `clk` input, 1: system clock.
- `reset` input, 1: synchronous, active-high.
- `record_button` input, 1: debounced, one-pulsed. Starts recording in IDLE; stops it in CAPTURE.
- `song` input, 2: target song slot, latched at record start.
- `beat` input, 1: one-cycle beat pulse, the same as `song_reader`.
- `key_note` input, 6: current note; 0 = rest.
- `wr_en` output, 1: song RAM write strobe, one cycle per entry.
- `wr_addr` output, 2+IDX_W: `{song_latched, index}`.
- `wr_data` output, 12: `{note[5:0], duration[5:0]}`.
- `recording` output, 1: high in CAPTURE, FLUSH and TERM.
- `full` output, 1: sticky once the last data slot is written; cleared at next record start.

## Operation
**States.** IDLE, CAPTURE, FLUSH, TERM.

**IDLE**
- On `record_button`: latch `song`, set index=0, `cur_note`=`key_note`, `dur`=0, clear `full`, then go to CAPTURE.
- Otherwise hold state. All outputs are 0 except `full`.

**CAPTURE**, evaluated each cycle:
- `beat`: `dur`+1.
- Key change (`key_note` != `cur_note`):
  - If the effective `dur` (after this cycle's beat increment) is 0, replace `cur_note` with no write. Sub-beat glitches are discarded.
  - Otherwise write `{cur_note, effective dur}`, set `cur_note`=`key_note`, `dur`=0.
- Saturation: if a beat brings `dur` to MAX_DUR with no key change, write `{cur_note, MAX_DUR}` and set `dur`=0. A held note continues in a new entry.
- Each write increments the index.
  - A write to index 2^IDX_W−2 sets `full` and goes to TERM.
  - Index 2^IDX_W−1 is reserved for the terminator.
- `record_button`:
  - If `dur`>0 (after this cycle's beat), go to FLUSH.
  - Otherwise go to TERM.
  - A key change in the same cycle is ignored.
- Rests (note 0) are recorded as ordinary entries.

**FLUSH:** write `{cur_note, dur}`, increment the index, then go to TERM.

**TERM:** write `12'h000` (end-of-song marker) at the current index, then go to IDLE.

**Other rules**
- At most one write per cycle.
- `record_button` outside IDLE and CAPTURE is ignored.
- Reset mid-recording aborts immediately. No terminator is written, and the RAM contents are undefined for that song.

## Timing
- `wr_en`, `wr_addr` and `wr_data` are registered. They assert the cycle after the triggering event (key change, saturating beat, FLUSH/TERM state entry).
- Start: `recording` rises one cycle after `record_button`.
- Stop latency:
  - 2 cycles to the terminator write with a pending entry (FLUSH, then TERM).
  - 1 cycle without a pending entry.
- `recording` falls the cycle after the TERM write.
- Reset values: state=IDLE, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `recording`=0, `full`=0, internal `dur`=0, index=0.
- Duration arithmetic is 6-bit and never wraps. The saturation write happens at exactly MAX_DUR.

## Structure
- Shared package `song_pkg`:
  - `NOTE_W`=6, `DUR_W`=6, `ENTRY_W`=12
  - `NOTE_REST`=0, `END_MARKER`=12'h000
  - the state encoding
- `song_reader` uses the same widths and marker from this package.
- Sub-module `duration_counter` covers the beat-driven 6-bit counter: clear, increment on `beat`, `at_max` flag, and a next-value output for same-cycle decisions.
- The FSM and address logic stay in `song_recorder`.

## Test plan
- Record with song=2. Hold note 20 for 3 beats, then note 0 for 2 beats, then press `record_button`. Required writes: addr `{2,0}`=`{20,3}`, `{2,1}`=`{0,2}`, `{2,2}`=12'h000. `recording` then drops.
- Change `key_note` twice within one beat, 5 → 7 → 9, then hold 9 for 1 beat and stop. Required: a single entry `{9,1}`; no writes for 5 or 7.
- Hold note 12 for 130 beats. Required: `{12,63}`, `{12,63}`, `{12,4}`, then the terminator.
- Change the key to 14 on the same cycle as a beat, with `dur`=1 before that beat. Required: the old entry is written with duration 2, and note 14 starts at 0.
- Play 31 distinct one-beat notes. Required: indices 0..30 are written, `full`=1, and the terminator lands at index 31 without any button press. Later key changes produce no writes.
- Assert `reset` two beats into a recording. Required: no further `wr_en`, all outputs 0 next cycle, and a fresh `record_button` restarts at index 0.
